// File: rtl/kronos_execute_pkg.sv
// kronos_types: EX-stage pipeline payloads, ALU opcodes and small helpers.
// Rev 1.0
`default_nettype none

package kronos_types;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] op3;
    logic [31:0] op4;
    logic [3:0]  aluop;
    logic [4:0]  rd;
    logic        rd_write;
    logic        branch;
    logic        branch_cond;
    logic [1:0]  ld_size;
    logic        ld_sign;
    logic        st;
    logic        illegal;
  } pipeIDEX_t;

  typedef struct packed {
    logic [31:0] result1;
    logic [31:0] result2;
    logic [4:0]  rd;
    logic        rd_write;
    logic        branch;
    logic        branch_cond;
    logic [1:0]  ld_size;
    logic        ld_sign;
    logic        st;
    logic        illegal;
  } pipeEXWB_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_NE   = 4'd11;
  localparam logic [3:0] ALU_GE   = 4'd12;
  localparam logic [3:0] ALU_GEU  = 4'd13;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  // Builds the WB payload: copies the control fields and forms the address sum.
  function automatic pipeEXWB_t make_exwb(input pipeIDEX_t d, input logic [31:0] r1);
    pipeEXWB_t e;
    e.result1     = r1;
    e.result2     = d.op3 + d.op4;
    e.rd          = d.rd;
    e.rd_write    = d.rd_write;
    e.branch      = d.branch;
    e.branch_cond = d.branch_cond;
    e.ld_size     = d.ld_size;
    e.ld_sign     = d.ld_sign;
    e.st          = d.st;
    e.illegal     = d.illegal;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kronos_execute_if.sv
// kronos_execute_if: ID->EX and EX->WB valid/ready channels seen by the execute stage.
// Rev 1.0
`default_nettype none

interface kronos_execute_if;
  import kronos_types::*;

  pipeIDEX_t decode;
  logic      pipe_in_vld;
  logic      pipe_in_rdy;
  pipeEXWB_t execute;
  logic      pipe_out_vld;
  logic      pipe_out_rdy;

  modport master (
    output decode, pipe_in_vld, pipe_out_rdy,
    input  pipe_in_rdy, execute, pipe_out_vld
  );

  modport slave (
    input  decode, pipe_in_vld, pipe_out_rdy,
    output pipe_in_rdy, execute, pipe_out_vld
  );
endinterface

`default_nettype wire

// File: rtl/kronos_execute_alu.sv
// kronos_alu: combinational result1 for all non-shift ALU operations.
// Rev 1.0
`default_nettype none

module kronos_alu
  import kronos_types::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [3:0]  aluop,
  output logic [31:0] result1
);

  always_comb begin
    result1 = 32'd0;
    case (aluop)
      ALU_ADD:  result1 = op1 + op2;
      ALU_SUB:  result1 = op1 - op2;
      ALU_AND:  result1 = op1 & op2;
      ALU_OR:   result1 = op1 | op2;
      ALU_XOR:  result1 = op1 ^ op2;
      ALU_SLT:  result1 = {31'd0, $signed(op1) < $signed(op2)};
      ALU_SLTU: result1 = {31'd0, op1 < op2};
      ALU_EQ:   result1 = {31'd0, op1 == op2};
      ALU_NE:   result1 = {31'd0, op1 != op2};
      ALU_GE:   result1 = {31'd0, $signed(op1) >= $signed(op2)};
      ALU_GEU:  result1 = {31'd0, op1 >= op2};
      default:  result1 = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/kronos_execute.sv
// kronos_execute: RV32I execute stage with a registered EX->WB output slot.
// Rev 1.0
`default_nettype none

module kronos_execute
  import kronos_types::*;
#(
  parameter bit FAST_SHIFT = 1'b1
) (
  input  logic              clk,
  input  logic              rstz,
  kronos_execute_if.slave   pipe
);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t      state;
  pipeEXWB_t   slot;
  pipeEXWB_t   pending;
  pipeEXWB_t   shift_done;
  logic        out_vld;
  logic [31:0] sh_data;
  logic [31:0] sh_next;
  logic [4:0]  sh_cnt;
  logic [3:0]  sh_op;
  logic [31:0] alu_result;
  logic [31:0] fast_shift;
  logic [31:0] result1;
  logic        in_rdy;
  logic        accept;
  logic        serial_op;

  kronos_alu u_alu (
    .op1     (pipe.decode.op1),
    .op2     (pipe.decode.op2),
    .aluop   (pipe.decode.aluop),
    .result1 (alu_result)
  );

  generate
    if (FAST_SHIFT) begin : g_fast_shift
      always_comb begin
        fast_shift = 32'd0;
        case (pipe.decode.aluop)
          ALU_SLL: fast_shift = pipe.decode.op1 << pipe.decode.op2[4:0];
          ALU_SRL: fast_shift = pipe.decode.op1 >> pipe.decode.op2[4:0];
          ALU_SRA: fast_shift = $signed(pipe.decode.op1) >>> pipe.decode.op2[4:0];
          default: fast_shift = 32'd0;
        endcase
      end
    end else begin : g_serial_shift
      assign fast_shift = 32'd0;
    end
  endgenerate

  assign result1   = is_shift(pipe.decode.aluop) ? fast_shift : alu_result;
  assign in_rdy    = (state == IDLE) && (!out_vld || pipe.pipe_out_rdy);
  assign accept    = pipe.pipe_in_vld && in_rdy;
  assign serial_op = (FAST_SHIFT == 1'b0) && is_shift(pipe.decode.aluop);

  // The final 1-bit step is folded into the completing cycle, so shamt=0 and 1 both take one SHIFT cycle.
  always_comb begin
    sh_next = sh_data;
    if (sh_cnt != 5'd0) begin
      case (sh_op)
        ALU_SLL: sh_next = {sh_data[30:0], 1'b0};
        ALU_SRL: sh_next = {1'b0, sh_data[31:1]};
        default: sh_next = {sh_data[31], sh_data[31:1]};
      endcase
    end
    shift_done         = pending;
    shift_done.result1 = sh_next;
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state   <= IDLE;
      out_vld <= 1'b0;
      slot    <= '0;
      pending <= '0;
      sh_data <= 32'd0;
      sh_cnt  <= 5'd0;
      sh_op   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (serial_op) begin
              state   <= SHIFT;
              out_vld <= 1'b0;
              pending <= make_exwb(pipe.decode, 32'd0);
              sh_data <= pipe.decode.op1;
              sh_cnt  <= pipe.decode.op2[4:0];
              sh_op   <= pipe.decode.aluop;
            end else begin
              slot    <= make_exwb(pipe.decode, result1);
              out_vld <= 1'b1;
            end
          end else if (pipe.pipe_out_rdy) begin
            out_vld <= 1'b0;
          end
        end
        SHIFT: begin
          if (sh_cnt <= 5'd1) begin
            slot    <= shift_done;
            out_vld <= 1'b1;
            state   <= IDLE;
          end else begin
            sh_data <= sh_next;
            sh_cnt  <= sh_cnt - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pipe.pipe_in_rdy  = in_rdy;
  assign pipe.pipe_out_vld = out_vld;
  assign pipe.execute      = slot;

endmodule

`default_nettype wire

// File: tb/tb_kronos_execute.sv
// tb_kronos_execute: directed and randomized checks of both shifter variants against a scoreboard model.
// Rev 1.0
`default_nettype none

module tb_kronos_execute;
  import kronos_types::*;

  logic clk = 1'b0;
  logic rstz = 1'b0;
  logic sel = 1'b0;
  pipeIDEX_t drv_dec = '0;
  logic drv_vld = 1'b0;
  logic drv_rdy = 1'b1;

  always #5 clk = ~clk;

  kronos_execute_if if_f ();
  kronos_execute_if if_s ();

  assign if_f.decode       = drv_dec;
  assign if_f.pipe_in_vld  = drv_vld && !sel;
  assign if_f.pipe_out_rdy = sel ? 1'b1 : drv_rdy;
  assign if_s.decode       = drv_dec;
  assign if_s.pipe_in_vld  = drv_vld && sel;
  assign if_s.pipe_out_rdy = sel ? drv_rdy : 1'b1;

  kronos_execute #(.FAST_SHIFT(1'b1)) dut_fast (.clk(clk), .rstz(rstz), .pipe(if_f.slave));
  kronos_execute #(.FAST_SHIFT(1'b0)) dut_serial (.clk(clk), .rstz(rstz), .pipe(if_s.slave));

  logic      cur_in_rdy, cur_out_vld;
  pipeEXWB_t cur_exec;
  assign cur_in_rdy  = sel ? if_s.pipe_in_rdy  : if_f.pipe_in_rdy;
  assign cur_out_vld = sel ? if_s.pipe_out_vld : if_f.pipe_out_vld;
  assign cur_exec    = sel ? if_s.execute      : if_f.execute;

  typedef struct { pipeEXWB_t exp; int ready_cyc; } item_t;
  item_t     sb[$];
  int        cyc = 0;
  int        busy_until = 0;
  logic      prev_hold = 1'b0;
  pipeEXWB_t prev_exec = '0;
  int        n_checks = 0;
  int        n_errors = 0;
  pipeIDEX_t idle_dec = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference ALU written from the opcode definitions, not from the RTL structure.
  function automatic logic [31:0] ref_r1(input pipeIDEX_t d);
    logic [31:0] a, b, fill, sa, sb_;
    int sh;
    a = d.op1; b = d.op2; sh = int'(d.op2[4:0]);
    sa = a ^ 32'h8000_0000; sb_ = b ^ 32'h8000_0000;
    fill = (a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    case (d.aluop)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return {31'd0, sa < sb_};
      4'd6:  return {31'd0, a < b};
      4'd7:  return a * (32'd1 << sh);
      4'd8:  return a >> sh;
      4'd9:  return (a >> sh) | fill;
      4'd10: return {31'd0, a == b};
      4'd11: return {31'd0, a != b};
      4'd12: return {31'd0, !(sa < sb_)};
      4'd13: return {31'd0, a >= b};
      default: return 32'd0;
    endcase
  endfunction

  function automatic pipeEXWB_t ref_exwb(input pipeIDEX_t d);
    pipeEXWB_t e;
    e.result1 = ref_r1(d);
    e.result2 = d.op3 + d.op4;
    e.rd = d.rd; e.rd_write = d.rd_write; e.branch = d.branch; e.branch_cond = d.branch_cond;
    e.ld_size = d.ld_size; e.ld_sign = d.ld_sign; e.st = d.st; e.illegal = d.illegal;
    return e;
  endfunction

  function automatic int ref_latency(input pipeIDEX_t d);
    int sh;
    sh = int'(d.op2[4:0]);
    if (sel && d.aluop >= 4'd7 && d.aluop <= 4'd9) return ((sh > 1) ? sh : 1) + 1;
    return 1;
  endfunction

  // One clock of stimulus; outputs and handshakes are evaluated 1 time unit after the falling edge.
  task automatic step(input pipeIDEX_t d, input logic v, input logic r);
    logic exp_vld, exp_rdy;
    @(negedge clk);
    drv_dec = d; drv_vld = v; drv_rdy = r;
    #1;
    cyc++;
    exp_vld = (sb.size() > 0) && (cyc >= sb[0].ready_cyc);
    exp_rdy = (cyc >= busy_until) && (!exp_vld || r);
    check("out_vld", 128'(cur_out_vld), 128'(exp_vld));
    check("in_rdy", 128'(cur_in_rdy), 128'(exp_rdy));
    if (exp_vld) check("execute", 128'(cur_exec), 128'(sb[0].exp));
    if (prev_hold) check("stable", 128'(cur_exec), 128'(prev_exec));
    prev_hold = cur_out_vld && !r;
    prev_exec = cur_exec;
    if (exp_vld && r) void'(sb.pop_front());
    if (v && exp_rdy) begin
      sb.push_back('{exp: ref_exwb(d), ready_cyc: cyc + ref_latency(d)});
      busy_until = cyc + ref_latency(d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) step(idle_dec, 1'b0, 1'b1);
    check("drain", 128'(sb.size()), 128'd0);
    step(idle_dec, 1'b0, 1'b1);
  endtask

  function automatic pipeIDEX_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    pipeIDEX_t d;
    d = '0; d.aluop = op; d.op1 = a; d.op2 = b;
    return d;
  endfunction

  function automatic pipeIDEX_t rand_dec();
    pipeIDEX_t d;
    d.op1 = $urandom; d.op2 = $urandom; d.op3 = $urandom; d.op4 = $urandom;
    d.aluop = 4'($urandom_range(0, 15));
    d.rd = 5'($urandom); d.rd_write = 1'($urandom); d.branch = 1'($urandom);
    d.branch_cond = 1'($urandom); d.ld_size = 2'($urandom); d.ld_sign = 1'($urandom);
    d.st = 1'($urandom); d.illegal = 1'($urandom);
    if ($urandom_range(0, 3) == 0) d.op2 = d.op1;
    if ($urandom_range(0, 3) == 0) d.op2[4:0] = 5'($urandom_range(0, 2));
    return d;
  endfunction

  task automatic shift_latency(input logic [31:0] a, input logic [31:0] b, input int exp_lat, input logic [31:0] exp_r);
    int start, lat;
    step(mk(ALU_SRA, a, b), 1'b1, 1'b1);
    start = cyc; lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      step(idle_dec, 1'b0, 1'b1);
      if (cur_out_vld) begin
        lat = cyc - start;
        check("sra_result", 128'(cur_exec.result1), 128'(exp_r));
      end
    end
    check("sra_latency", 128'(lat), 128'(exp_lat));
  endtask

  initial begin
    pipeIDEX_t d;
    repeat (3) @(negedge clk);
    #1;
    check("rst_vld_fast", 128'(if_f.pipe_out_vld), 128'd0);
    check("rst_vld_serial", 128'(if_s.pipe_out_vld), 128'd0);
    check("rst_slot_fast", 128'(if_f.execute), 128'd0);
    check("rst_slot_serial", 128'(if_s.execute), 128'd0);
    @(negedge clk) rstz = 1'b1;

    // ADD wrap and address sum
    d = mk(ALU_ADD, 32'hFFFF_FFFF, 32'd1); d.op3 = 32'h100; d.op4 = 32'h20; d.rd = 5'd5; d.rd_write = 1'b1;
    step(d, 1'b1, 1'b0);
    step(idle_dec, 1'b0, 1'b1);
    check("add_r1", 128'(cur_exec.result1), 128'd0);
    check("add_r2", 128'(cur_exec.result2), 128'h120);
    check("add_rd", 128'(cur_exec.rd), 128'd5);

    // SLT held under back-pressure
    step(mk(ALU_SLT, 32'h8000_0000, 32'd1), 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(idle_dec, 1'b0, 1'b0);
      check("slt_hold", 128'(cur_exec.result1), 128'd1);
      check("slt_in_rdy", 128'(cur_in_rdy), 128'd0);
    end
    step(idle_dec, 1'b0, 1'b1);

    // Eight back-to-back XORs
    for (int i = 0; i < 8; i++) step(mk(ALU_XOR, $urandom, $urandom), 1'b1, 1'b1);
    drain();

    d = mk(ALU_GEU, 32'd2, 32'hFFFF_FFFE); d.branch_cond = 1'b1;
    step(d, 1'b1, 1'b1);
    d = mk(ALU_EQ, 32'd7, 32'd7); d.branch_cond = 1'b1;
    step(d, 1'b1, 1'b1);
    check("geu_r1", 128'(cur_exec.result1), 128'd0);
    check("geu_bc", 128'(cur_exec.branch_cond), 128'd1);
    d = mk(4'd15, 32'd3, 32'd4); d.illegal = 1'b1;
    step(d, 1'b1, 1'b1);
    check("eq_r1", 128'(cur_exec.result1), 128'd1);
    check("eq_bc", 128'(cur_exec.branch_cond), 128'd1);
    step(idle_dec, 1'b0, 1'b1);
    check("illegal_fwd", 128'(cur_exec.illegal), 128'd1);
    check("undef_r1", 128'(cur_exec.result1), 128'd0);
    drain();

    for (int i = 0; i < 300; i++) step(rand_dec(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    drain();

    // Serial shifter
    sel = 1'b1; prev_hold = 1'b0;
    shift_latency(32'h8000_0000, 32'd31, 32, 32'hFFFF_FFFF);
    shift_latency(32'h8000_0000, 32'd0, 2, 32'h8000_0000);
    for (int i = 0; i < 300; i++) step(rand_dec(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    drain();

    // Reset during the third SHIFT cycle discards the op
    step(mk(ALU_SRA, 32'h8000_0000, 32'd31), 1'b1, 1'b1);
    step(idle_dec, 1'b0, 1'b1);
    step(idle_dec, 1'b0, 1'b1);
    @(negedge clk) rstz = 1'b0;
    #1;
    check("rst_mid_vld", 128'(cur_out_vld), 128'd0);
    sb.delete(); busy_until = 0; prev_hold = 1'b0;
    @(negedge clk) rstz = 1'b1;
    for (int i = 0; i < 40; i++) step(idle_dec, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
